// File: rtl/aes_iter_ctrl.sv
// Iterative AES-128 encryption controller: one round datapath reused over ten cycles,
// valid/ready on both sides, ciphertext held in DONE until the consumer takes it.
module aes_iter_ctrl (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [0:127] plaintext,
   input  logic [0:127] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [0:127] ciphertext,
   output logic         busy,
   output logic [3:0]   cur_round
);

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   state_t       state_reg, state_next;
   logic [0:127] st_reg, st_next;
   logic [0:127] rk_reg, rk_next;
   logic [7:0]   rc_reg, rc_next;
   logic [3:0]   round_reg, round_next;

   logic [0:127] sb, sr, mx, next_rk;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box built algebraically: inverse as x^254 (maps 0 to 0), then the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] p;
      logic [7:0] r;
      p = x;
      r = 8'h01;
      for (int i = 0; i < 7; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [0:127] sub_byte(input logic [0:127] s);
      logic [0:127] o;
      o = '0;
      for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
      return o;
   endfunction

   // Byte 4c+r holds row r of column c; row r rotates left by r columns.
   function automatic logic [0:127] shift_row(input logic [0:127] s);
      logic [0:127] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
      return o;
   endfunction

   function automatic logic [0:127] mix_col(input logic [0:127] s);
      logic [0:127] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[32*c +: 8];
         a1 = s[32*c+8 +: 8];
         a2 = s[32*c+16 +: 8];
         a3 = s[32*c+24 +: 8];
         o[32*c +: 8]    = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[32*c+8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   function automatic logic [0:127] key_expand(input logic [0:127] k, input logic [31:0] rcon);
      logic [31:0]  w [4];
      logic [31:0]  t;
      logic [0:127] o;
      for (int j = 0; j < 4; j++) w[j] = k[32*j +: 32];
      t = {sbox(w[3][23:16]), sbox(w[3][15:8]), sbox(w[3][7:0]), sbox(w[3][31:24])} ^ rcon;
      w[0] = w[0] ^ t;
      w[1] = w[1] ^ w[0];
      w[2] = w[2] ^ w[1];
      w[3] = w[3] ^ w[2];
      o = '0;
      for (int j = 0; j < 4; j++) o[32*j +: 32] = w[j];
      return o;
   endfunction

   assign sb      = sub_byte(st_reg);
   assign sr      = shift_row(sb);
   // The final round skips MixColumns.
   assign mx      = (round_reg == 4'd10) ? sr : mix_col(sr);
   assign next_rk = key_expand(rk_reg, {rc_reg, 24'h000000});

   always_comb begin
      state_next = state_reg;
      st_next    = st_reg;
      rk_next    = rk_reg;
      rc_next    = rc_reg;
      round_next = round_reg;
      out_valid  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (in_valid && !rst) begin
               st_next    = plaintext ^ key;
               rk_next    = key;
               rc_next    = 8'h01;
               round_next = 4'd1;
               state_next = ROUND;
            end
         end
         ROUND: begin
            st_next = mx ^ next_rk;
            rk_next = next_rk;
            rc_next = xtime(rc_reg);
            if (round_reg == 4'd10) state_next = DONE;
            else                    round_next = round_reg + 4'd1;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
               round_next = 4'd0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         st_reg    <= '0;
         rk_reg    <= '0;
         rc_reg    <= 8'h01;
         round_reg <= 4'd0;
      end else begin
         state_reg <= state_next;
         st_reg    <= st_next;
         rk_reg    <= rk_next;
         rc_reg    <= rc_next;
         round_reg <= round_next;
      end
   end

   assign in_ready   = (state_reg == IDLE) && !rst;
   assign busy       = (state_reg != IDLE);
   assign ciphertext = st_reg;
   assign cur_round  = round_reg;

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// Bench for aes_iter_ctrl: FIPS-197 vectors, backpressure, back-to-back, abort and
// randomized blocks checked against a table-driven AES-128 model.
module tb_aes_iter_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] plaintext;
   logic [127:0] key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] ciphertext;
   logic         busy;
   logic [3:0]   cur_round;

   int errors = 0;
   int checks = 0;

   logic [7:0] sbox_tab [256];

   localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_R1  = 128'ha49c7ff2689f352b6b5bea43026a5049;
   localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   aes_iter_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .plaintext  (plaintext),
      .key        (key),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ciphertext (ciphertext),
      .busy       (busy),
      .cur_round  (cur_round)
   );

   always #5 clk = ~clk;

   task automatic load_sbox();
      logic [2047:0] bits;
      bits = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
              128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
              128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
              128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
              128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
              128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
              128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
              128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
      for (int i = 0; i < 256; i++) sbox_tab[i] = bits[2047-8*i -: 8];
   endtask

   function automatic logic [7:0] mul2(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // FIPS-197 cipher on a 4x4 row/column array with the full key schedule precomputed.
   function automatic logic [127:0] ref_aes(input logic [127:0] pt, input logic [127:0] k);
      logic [7:0]   s [4][4];
      logic [7:0]   t [4][4];
      logic [31:0]  w [44];
      logic [31:0]  tmp;
      logic [7:0]   rcon [10];
      logic [127:0] ct;
      rcon = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0)
            tmp = {sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]],
                   sbox_tab[tmp[31:24]]} ^ {rcon[i/4-1], 24'h000000};
         w[i] = w[i-4] ^ tmp;
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               t[r][c] = sbox_tab[s[r][(c+r)%4]];
         for (int c = 0; c < 4; c++) begin
            if (rnd < 10) begin
               s[0][c] = mul2(t[0][c]) ^ mul2(t[1][c]) ^ t[1][c] ^ t[2][c] ^ t[3][c];
               s[1][c] = t[0][c] ^ mul2(t[1][c]) ^ mul2(t[2][c]) ^ t[2][c] ^ t[3][c];
               s[2][c] = t[0][c] ^ t[1][c] ^ mul2(t[2][c]) ^ mul2(t[3][c]) ^ t[3][c];
               s[3][c] = mul2(t[0][c]) ^ t[0][c] ^ t[1][c] ^ t[2][c] ^ mul2(t[3][c]);
            end else begin
               for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
            end
            for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
         end
      end
      ct = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            ct[127-8*(4*c+r) -: 8] = s[r][c];
      return ct;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [127:0] p, input logic [127:0] k);
      plaintext = p;
      key       = k;
      in_valid  = 1'b1;
      step();
      in_valid  = 1'b0;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (out_valid !== 1'b1 && n < 40) begin
         step();
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; plaintext = '0; key = '0;
      step(); step();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      checks++; if (cur_round !== 4'd0) begin errors++; $display("FAIL rst_round got=%0d exp=0", cur_round); end
      checks++; if (ciphertext !== 128'h0) begin errors++; $display("FAIL rst_ct got=%h exp=0", ciphertext); end
   endtask

   task automatic test_fips_b();
      int n;
      out_ready = 1'b1;
      send(B_PT, B_KEY);
      checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL b_accept busy=%b in_ready=%b exp busy=1 in_ready=0", busy, in_ready); end
      checks++; if (cur_round !== 4'd1) begin errors++; $display("FAIL b_round0 got=%0d exp=1", cur_round); end
      checks++; if (ciphertext !== (B_PT ^ B_KEY)) begin errors++; $display("FAIL b_st0 got=%h exp=%h", ciphertext, B_PT ^ B_KEY); end
      step();
      checks++; if (ciphertext !== B_R1) begin errors++; $display("FAIL b_st1 got=%h exp=%h", ciphertext, B_R1); end
      wait_out(n);
      checks++; if (n != 9) begin errors++; $display("FAIL b_latency got=%0d exp=9 edges after E1", n); end
      checks++; if (ciphertext !== B_CT) begin errors++; $display("FAIL b_ct got=%h exp=%h", ciphertext, B_CT); end
      checks++; if (cur_round !== 4'd10) begin errors++; $display("FAIL b_round_done got=%0d exp=10", cur_round); end
      $display("txn fips_b pt=%h ct=%h", B_PT, ciphertext);
      step();
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b_release out_valid=%b busy=%b exp 0 0", out_valid, busy); end
      checks++; if (cur_round !== 4'd0) begin errors++; $display("FAIL b_round_idle got=%0d exp=0", cur_round); end
   endtask

   task automatic test_fips_c1();
      out_ready = 1'b1;
      send(C_PT, C_KEY);
      for (int k = 1; k <= 10; k++) begin
         checks++; if (cur_round !== 4'(k)) begin errors++; $display("FAIL c1_round got=%0d exp=%0d", cur_round, k); end
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL c1_early_valid round=%0d got=%b exp=0", k, out_valid); end
         step();
      end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL c1_valid got=%b exp=1", out_valid); end
      checks++; if (ciphertext !== C_CT) begin errors++; $display("FAIL c1_ct got=%h exp=%h", ciphertext, C_CT); end
      $display("txn fips_c1 pt=%h ct=%h", C_PT, ciphertext);
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL c1_release busy=%b exp=0", busy); end
   endtask

   task automatic test_backpressure();
      int n;
      out_ready = 1'b0;
      send(B_PT, B_KEY);
      wait_out(n);
      checks++; if (n != 10) begin errors++; $display("FAIL bp_latency got=%0d exp=10", n); end
      for (int i = 0; i < 20; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         plaintext = rand128();
         key       = rand128();
         step();
         checks++; if (ciphertext !== B_CT) begin errors++; $display("FAIL bp_hold cyc=%0d got=%h exp=%h", i, ciphertext, B_CT); end
         checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_flags cyc=%0d in_ready=%b out_valid=%b exp 0 1", i, in_ready, out_valid); end
      end
      $display("txn backpressure ct=%h", ciphertext);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release out_valid=%b busy=%b exp 0 0", out_valid, busy); end
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_no_queue busy=%b exp=0", busy); end
   endtask

   task automatic test_back_to_back();
      int             hs[$];
      logic [127:0]   cts[$];
      out_ready = 1'b1;
      plaintext = B_PT; key = B_KEY; in_valid = 1'b1;
      if (in_ready) hs.push_back(0);
      step();
      plaintext = C_PT; key = C_KEY;
      for (int e = 1; e <= 23; e++) begin
         if (in_valid && in_ready) hs.push_back(e);
         if (out_valid && out_ready) cts.push_back(ciphertext);
         step();
         if (hs.size() >= 2) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      checks++; if (hs.size() != 2) begin errors++; $display("FAIL b2b_hs_count got=%0d exp=2", hs.size()); end
      else begin
         checks++; if (hs[0] != 0 || hs[1] != 12) begin errors++; $display("FAIL b2b_hs_edges got=%0d,%0d exp=0,12", hs[0], hs[1]); end
      end
      checks++; if (cts.size() != 2) begin errors++; $display("FAIL b2b_ct_count got=%0d exp=2", cts.size()); end
      else begin
         checks++; if (cts[0] !== B_CT) begin errors++; $display("FAIL b2b_ct0 got=%h exp=%h", cts[0], B_CT); end
         checks++; if (cts[1] !== C_CT) begin errors++; $display("FAIL b2b_ct1 got=%h exp=%h", cts[1], C_CT); end
         $display("txn back_to_back ct0=%h ct1=%h", cts[0], cts[1]);
      end
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle busy=%b exp=0", busy); end
   endtask

   task automatic test_reset_mid();
      int n;
      out_ready = 1'b1;
      send(rand128(), rand128());
      n = 0;
      while (cur_round !== 4'd5 && n < 20) begin
         step();
         n++;
      end
      checks++; if (cur_round !== 4'd5) begin errors++; $display("FAIL abort_reach_r5 got=%0d exp=5", cur_round); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL abort_state busy=%b out_valid=%b exp 0 0", busy, out_valid); end
      checks++; if (cur_round !== 4'd0) begin errors++; $display("FAIL abort_round got=%0d exp=0", cur_round); end
      checks++; if (ciphertext !== 128'h0) begin errors++; $display("FAIL abort_ct got=%h exp=0", ciphertext); end
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
      send(C_PT, C_KEY);
      wait_out(n);
      checks++; if (ciphertext !== C_CT || n != 10) begin errors++; $display("FAIL abort_rerun ct=%h after %0d edges exp ct=%h after 10", ciphertext, n, C_CT); end
      $display("txn after_abort ct=%h", ciphertext);
      step();
   endtask

   task automatic test_change_inputs();
      int n;
      out_ready = 1'b1;
      send(B_PT, B_KEY);
      plaintext = rand128();
      key       = rand128();
      step();
      plaintext = rand128();
      key       = rand128();
      wait_out(n);
      checks++; if (ciphertext !== B_CT) begin errors++; $display("FAIL chg_ct got=%h exp=%h", ciphertext, B_CT); end
      $display("txn change_inputs ct=%h", ciphertext);
      step();
   endtask

   task automatic test_random();
      int           n;
      int           d;
      logic [127:0] p;
      logic [127:0] k;
      logic [127:0] exp_ct;
      for (int t = 0; t < 24; t++) begin
         p = rand128();
         k = rand128();
         if (t == 0) p = '0;
         if (t == 1) k = '1;
         exp_ct = ref_aes(p, k);
         out_ready = 1'b0;
         send(p, k);
         wait_out(n);
         checks++; if (n != 10) begin errors++; $display("FAIL rnd_latency txn=%0d got=%0d exp=10", t, n); end
         checks++; if (ciphertext !== exp_ct) begin errors++; $display("FAIL rnd_ct txn=%0d got=%h exp=%h", t, ciphertext, exp_ct); end
         $display("txn rnd %0d pt=%h key=%h ct=%h", t, p, k, ciphertext);
         d = $urandom_range(0, 3);
         for (int i = 0; i < d; i++) step();
         out_ready = 1'b1;
         step();
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_release txn=%0d busy=%b exp=0", t, busy); end
         d = $urandom_range(0, 2);
         for (int i = 0; i < d; i++) step();
      end
   endtask

   initial begin
      load_sbox();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; plaintext = '0; key = '0;
      test_reset();
      test_fips_b();
      test_fips_c1();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_change_inputs();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
